// File: rtl/mcs4_clkgen_if.sv
// Control and clock-output bundle of the MCS-4 two-phase clock generator.
// master: the controlling side (drives run/poc_req, observes the clocks).
// slave:  the clock generator itself.
interface mcs4_clkgen_if;
  logic run;
  logic poc_req;
  logic clk1;
  logic clk2;
  logic poc;
  logic period_strobe;
  logic running;

  modport master (
    output run, poc_req,
    input  clk1, clk2, poc, period_strobe, running
  );

  modport slave (
    input  run, poc_req,
    output clk1, clk2, poc, period_strobe, running
  );
endinterface

// File: rtl/mcs4_clkgen.sv
// MCS-4 two-phase non-overlapping clock generator with power-on-clear.
// A five-state FSM (IDLE, PH1, GAP1, PH2, GAP2) timed by one shared
// down-counter produces clk1/clk2. All outputs come straight from flops
// whose next values are decoded from the next FSM state.
module mcs4_clkgen #(
  parameter int CLK1_HIGH   = 6,
  parameter int GAP1        = 2,
  parameter int CLK2_HIGH   = 6,
  parameter int GAP2        = 2,
  parameter int POC_PERIODS = 64
) (
  input  logic          sysclk,
  input  logic          reset,
  mcs4_clkgen_if.slave  bus
);

  // Every phase and the POC length must be non-zero.
  if (CLK1_HIGH < 1 || GAP1 < 1 || CLK2_HIGH < 1 || GAP2 < 1 || POC_PERIODS < 1) begin : g_param_check
    $error("mcs4_clkgen: every timing parameter must be at least 1");
  end

  localparam int MAX_A  = (CLK1_HIGH > GAP1) ? CLK1_HIGH : GAP1;
  localparam int MAX_B  = (CLK2_HIGH > GAP2) ? CLK2_HIGH : GAP2;
  localparam int MAX_PH = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W  = $clog2(MAX_PH + 1);
  localparam int POC_W  = $clog2(POC_PERIODS + 1);

  localparam logic [CNT_W-1:0] CLK1_LD = CNT_W'(CLK1_HIGH - 1);
  localparam logic [CNT_W-1:0] GAP1_LD = CNT_W'(GAP1 - 1);
  localparam logic [CNT_W-1:0] CLK2_LD = CNT_W'(CLK2_HIGH - 1);
  localparam logic [CNT_W-1:0] GAP2_LD = CNT_W'(GAP2 - 1);
  localparam logic [POC_W-1:0] POC_MAX = POC_W'(POC_PERIODS);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PH1  = 3'd1,
    S_GAP1 = 3'd2,
    S_PH2  = 3'd3,
    S_GAP2 = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [POC_W-1:0]   poc_cnt_q, poc_cnt_d;
  logic               valid_q, valid_d;   // current period began at or after the last poc_req
  logic               poc_q, poc_d;
  logic               clk1_q, clk1_d;
  logic               clk2_q, clk2_d;
  logic               strobe_q, strobe_d;
  logic               running_q, running_d;
  logic               period_done;

  // State register, phase counter, POC bookkeeping and output flops.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      poc_cnt_q <= '0;
      valid_q   <= 1'b0;
      poc_q     <= 1'b1;
      clk1_q    <= 1'b0;
      clk2_q    <= 1'b0;
      strobe_q  <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      poc_cnt_q <= poc_cnt_d;
      valid_q   <= valid_d;
      poc_q     <= poc_d;
      clk1_q    <= clk1_d;
      clk2_q    <= clk2_d;
      strobe_q  <= strobe_d;
      running_q <= running_d;
    end
  end

  // Next-state logic: each phase lasts (load + 1) cycles; run is only
  // consulted in IDLE and at the end of GAP2, so periods never truncate.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (bus.run) begin
          state_d = S_PH1;
          cnt_d   = CLK1_LD;
        end
      end
      S_PH1: begin
        if (cnt_q == '0) begin
          state_d = S_GAP1;
          cnt_d   = GAP1_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_GAP1: begin
        if (cnt_q == '0) begin
          state_d = S_PH2;
          cnt_d   = CLK2_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_PH2: begin
        if (cnt_q == '0) begin
          state_d = S_GAP2;
          cnt_d   = GAP2_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_GAP2: begin
        if (cnt_q == '0) begin
          if (bus.run) begin
            state_d = S_PH1;
            cnt_d   = CLK1_LD;
          end else begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Clock outputs decoded from the next state so they are registered.
  always_comb begin
    clk1_d      = (state_d == S_PH1);
    clk2_d      = (state_d == S_PH2);
    running_d   = (state_d != S_IDLE);
    strobe_d    = (state_d == S_PH1) && (state_q != S_PH1);
    period_done = (state_q == S_GAP2) && (cnt_q == '0);
  end

  // POC: count whole periods begun after the last request; release poc on a clk1 rise.
  always_comb begin
    poc_cnt_d = poc_cnt_q;
    valid_d   = valid_q;
    poc_d     = poc_q;
    if (period_done && valid_q && (poc_cnt_q != POC_MAX)) begin
      poc_cnt_d = poc_cnt_q + 1'b1;
    end
    // A period starting on this edge lies entirely after any request seen now.
    if (strobe_d) begin
      valid_d = 1'b1;
    end else if (bus.poc_req) begin
      valid_d = 1'b0;
    end
    if (bus.poc_req) begin
      poc_cnt_d = '0;
      poc_d     = 1'b1;
    end else if (poc_q && strobe_d && (poc_cnt_d == POC_MAX)) begin
      poc_d = 1'b0;
    end
  end

  assign bus.clk1          = clk1_q;
  assign bus.clk2          = clk2_q;
  assign bus.poc           = poc_q;
  assign bus.period_strobe = strobe_q;
  assign bus.running       = running_q;

endmodule

// File: tb/tb_mcs4_clkgen.sv
// Self-checking bench for mcs4_clkgen: hand-written vector table, directed
// POC/run scenarios and random stimulus against a period-position model.
module tb_mcs4_clkgen;
  localparam int C1 = 6;
  localparam int G1 = 2;
  localparam int C2 = 6;
  localparam int G2 = 2;
  localparam int NP = 64;
  localparam int P  = C1 + G1 + C2 + G2;

  logic sysclk = 1'b0;
  logic reset;
  mcs4_clkgen_if bus ();

  mcs4_clkgen #(
    .CLK1_HIGH(C1), .GAP1(G1), .CLK2_HIGH(C2), .GAP2(G2), .POC_PERIODS(NP)
  ) dut (
    .sysclk(sysclk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 sysclk = ~sysclk;

  int errors = 0;
  int checks = 0;

  // Reference model: position inside the period (-1 = stopped), number of
  // whole periods finished since the last clear, and the poc level.
  int m_pos    = -1;
  int m_done   = 0;
  bit m_ok     = 1'b0;
  bit m_poc    = 1'b1;
  bit m_strobe = 1'b0;

  task automatic model_edge(input bit r, input bit rn, input bit rq);
    bit fin;
    if (r) begin
      m_pos = -1; m_done = 0; m_ok = 1'b0; m_poc = 1'b1; m_strobe = 1'b0;
    end else begin
      fin = (m_pos == P - 1);
      if (fin && m_ok && m_done < NP) m_done++;
      if (m_pos == -1 || m_pos == P - 1) m_pos = rn ? 0 : -1;
      else m_pos++;
      m_strobe = (m_pos == 0);
      if (m_strobe) m_ok = 1'b1;
      else if (rq) m_ok = 1'b0;
      if (rq) begin
        m_done = 0; m_poc = 1'b1;
      end else if (m_poc && m_strobe && m_done >= NP) begin
        m_poc = 1'b0;
      end
    end
  endtask

  // Output order everywhere: {clk1, clk2, poc, period_strobe, running}
  function automatic logic [4:0] model_out();
    logic c1, c2, rn;
    c1 = (m_pos >= 0) && (m_pos < C1);
    c2 = (m_pos >= C1 + G1) && (m_pos < C1 + G1 + C2);
    rn = (m_pos >= 0);
    return {c1, c2, m_poc, m_strobe, rn};
  endfunction

  function automatic logic [4:0] dut_out();
    return {bus.clk1, bus.clk2, bus.poc, bus.period_strobe, bus.running};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One sysclk cycle: drive inputs, clock, advance model, compare #1 later.
  task automatic step(input bit r, input bit rn, input bit rq);
    reset = r; bus.run = rn; bus.poc_req = rq;
    @(posedge sysclk);
    model_edge(r, rn, rq);
    #1;
    checks++;
    if (dut_out() !== model_out()) begin
      errors++;
      $display("FAIL model: got %b expected %b at %0t", dut_out(), model_out(), $time);
    end
  endtask

  // Run with run=1 until poc falls; returns clk1 rises seen, -1 on timeout.
  task automatic strobes_until_poc_low(output int n);
    n = 0;
    for (int i = 0; i < (NP + 3) * P; i++) begin
      step(1'b0, 1'b1, 1'b0);
      if (bus.period_strobe) n++;
      if (!bus.poc) return;
    end
    n = -1;
  endtask

  typedef struct {
    string      name;
    bit         r;
    bit         rn;
    bit         rq;
    int         n;
    logic [4:0] exp;
  } vec_t;

  vec_t tbl[15];

  initial begin
    int n;
    int c2cnt, gapcnt, pochigh;

    bus.run = 1'b0; bus.poc_req = 1'b0; reset = 1'b1;

    tbl[0]  = '{"reset_state",   1, 0, 0, 3,  5'b00100};
    tbl[1]  = '{"first_rise",    0, 1, 0, 1,  5'b10111};
    tbl[2]  = '{"ph1_last",      0, 1, 0, 5,  5'b10101};
    tbl[3]  = '{"gap1_first",    0, 1, 0, 1,  5'b00101};
    tbl[4]  = '{"ph2_first",     0, 1, 0, 2,  5'b01101};
    tbl[5]  = '{"ph2_last",      0, 1, 0, 5,  5'b01101};
    tbl[6]  = '{"gap2_first",    0, 1, 0, 1,  5'b00101};
    tbl[7]  = '{"second_rise",   0, 1, 0, 2,  5'b10111};
    tbl[8]  = '{"run_low_gap2",  0, 0, 0, 15, 5'b00101};
    tbl[9]  = '{"idle_entry",    0, 0, 0, 1,  5'b00100};
    tbl[10] = '{"idle_hold",     0, 0, 0, 3,  5'b00100};
    tbl[11] = '{"restart_rise",  0, 1, 0, 1,  5'b10111};
    tbl[12] = '{"reset_mid_ph1", 1, 1, 0, 1,  5'b00100};
    tbl[13] = '{"after_reset",   0, 1, 0, 1,  5'b10111};
    tbl[14] = '{"req_in_ph1",    0, 1, 1, 1,  5'b10101};

    for (int i = 0; i < 15; i++) begin
      for (int k = 0; k < tbl[i].n; k++) step(tbl[i].r, tbl[i].rn, tbl[i].rq);
      check(tbl[i].name, int'(dut_out()), int'(tbl[i].exp));
      $display("vec %0d %s outputs=%b", i, tbl[i].name, dut_out());
    end

    // Startup: poc held through 64 periods, falls on the 65th clk1 rise.
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    strobes_until_poc_low(n);
    check("startup_poc_rises", n, NP + 1);
    check("startup_poc_on_strobe", int'(bus.period_strobe), 1);
    $display("startup: poc fell after %0d clk1 rises", n);

    // 1000 back-to-back periods; poc must stay low.
    n = 0; pochigh = 0;
    for (int i = 0; i < 1000 * P; i++) begin
      step(1'b0, 1'b1, 1'b0);
      if (bus.period_strobe) n++;
      if (bus.poc) pochigh++;
    end
    check("periods_in_16000", n, 1000);
    check("poc_stays_low", pochigh, 0);
    $display("free run: %0d periods", n);

    // poc_req pulse mid-period: poc high next edge, falls on the 65th rise.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    check("req_sets_poc", int'(bus.poc), 1);
    strobes_until_poc_low(n);
    check("req_poc_rises", n, NP + 1);
    $display("poc_req: poc fell after %0d clk1 rises", n);

    // poc_req on the edge that would release poc: poc stays, 64 more periods.
    step(1'b1, 1'b0, 1'b0);
    n = 0;
    for (int i = 0; i < (NP + 2) * P && n < NP; i++) begin
      step(1'b0, 1'b1, 1'b0);
      if (bus.period_strobe) n++;
    end
    check("reach_64_rises", n, NP);
    for (int i = 0; i < P - 1; i++) step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    check("collide_strobe", int'(bus.period_strobe), 1);
    check("collide_poc_kept", int'(bus.poc), 1);
    strobes_until_poc_low(n);
    check("collide_poc_rises", n, NP);
    $display("collision: poc fell after %0d further clk1 rises", n);

    // Drop run in PH2: clk2 and GAP2 finish, then IDLE; restart one cycle later.
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0);
    check("in_ph2", int'(bus.clk2), 1);
    c2cnt = 1; gapcnt = 0;
    for (int i = 0; i < 40 && bus.running; i++) begin
      step(1'b0, 1'b0, 1'b0);
      if (bus.clk2) c2cnt++;
      else if (bus.running) gapcnt++;
    end
    check("drop_clk2_cycles", c2cnt, C2);
    check("drop_gap2_cycles", gapcnt, G2);
    check("drop_idle", int'(dut_out()), 5'b00000);
    step(1'b0, 1'b1, 1'b0);
    check("rerun_clk1", int'(bus.clk1), 1);
    $display("run drop: clk2=%0d gap2=%0d", c2cnt, gapcnt);

    // Random run/poc_req/reset against the model.
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 499) == 0), ($urandom_range(0, 9) != 0),
           ($urandom_range(0, 299) == 0));
    end
    $display("random: 4000 cycles");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mcs4_clkgen.md
MCS4_CLKGEN -- requirements
Module: mcs4_clkgen

Interface
REQ-001 Parameter CLK1_HIGH, default 6, sysclk cycles clk1 is high per period.
REQ-002 Parameter GAP1, default 2, sysclk cycles from clk1 fall to clk2 rise, with both clocks low.
REQ-003 Parameter CLK2_HIGH, default 6, sysclk cycles clk2 is high per period.
REQ-004 Parameter GAP2, default 2, sysclk cycles from clk2 fall to the next clk1 rise, with both clocks low.
REQ-005 Parameter POC_PERIODS, default 64, number of complete clock periods poc is held after reset or poc_req.
REQ-006 sysclk  input  1  the single system clock; every flop in the block is clocked on its rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 run  input  1  level; high lets the clocks run, low stops them cleanly at the end of a period.
REQ-009 poc_req  input  1  level or pulse; requests a power-on-clear sequence.
REQ-010 clk1  output  1  MCS-4 phase-1 clock; feeds clk1_pad of the CPU and the i4001/i4002 chips.
REQ-011 clk2  output  1  MCS-4 phase-2 clock; feeds clk2_pad.
REQ-012 poc  output  1  power-on clear; feeds poc_pad.
REQ-013 period_strobe  output  1  one-sysclk pulse marking each clk1 rise.
REQ-014 running  output  1  high while a clock period is in progress.

Function
REQ-015 All outputs are registered; there is no combinational path from an input to an output.
REQ-016 FSM states are IDLE, PH1, GAP1, PH2 and GAP2; a down-counter sized to the largest parameter times each state.
REQ-017 clk1 is high exactly in PH1 and clk2 is high exactly in PH2; clk1 and clk2 are never high in the same sysclk cycle.
REQ-018 In IDLE, when run is sampled high, the FSM enters PH1 on the next edge; clk1 and period_strobe go high in that same cycle.
REQ-019 PH1 lasts CLK1_HIGH cycles, then GAP1 lasts GAP1 cycles, then PH2 lasts CLK2_HIGH cycles, then GAP2 lasts GAP2 cycles.
REQ-020 At the end of GAP2 the FSM goes to PH1 if run is high and to IDLE if run is low; with run held high the period is exactly CLK1_HIGH+GAP1+CLK2_HIGH+GAP2 cycles, back to back.
REQ-021 Dropping run in mid-period does not truncate that period; the period always finishes through GAP2.
REQ-022 running is high in PH1, GAP1, PH2 and GAP2, and low in IDLE.
REQ-023 A period is counted as complete when its GAP2 ends.
REQ-024 The POC counter advances only on complete periods, and does not advance while the FSM is in IDLE.
REQ-025 poc deasserts only on the edge where clk1 rises, and only after POC_PERIODS complete periods have been counted since the last reset or poc_req.
REQ-026 A poc_req sampled high sets poc high on the next edge, clears the POC counter, and keeps the counter cleared for as long as poc_req stays high.
REQ-027 poc_req has no effect on the clock FSM.
REQ-028 If poc_req is sampled high in the same cycle that would otherwise deassert poc, poc_req wins: poc stays high and the count restarts.
REQ-029 The POC counter saturates and does not wrap; poc stays low until the next reset or poc_req.
REQ-030 Every parameter is at least 1; an elaboration-time check fails if any parameter is 0.

Reset
REQ-031 While reset is high, the FSM is forced to IDLE, the counters are cleared, clk1=0, clk2=0, period_strobe=0, running=0 and poc=1.
REQ-032 reset asserted in mid-period aborts the period immediately; clk1 or clk2 falls on the next edge.
REQ-033 After reset is released, the block behaves as if poc_req had been received: the full POC_PERIODS sequence follows.

Verification
REQ-034 Default parameters, reset released, run=1 held -> clk1 high for 6 cycles, low for 2, clk2 high for 6, low for 2; period 16 cycles; no overlap, checked over 1000 periods.
REQ-035 Reset released with run=1 -> poc=1 through 64 complete periods; poc falls on the same edge as the 65th clk1 rise (period_strobe); poc stays low afterwards.
REQ-036 run dropped during PH2 of period 10 -> clk2 completes its 6 cycles and GAP2 completes; then IDLE with clk1, clk2 and running at 0; run raised again -> clk1 rises one cycle later.
REQ-037 poc_req pulsed for 1 cycle at period 20 after poc has cleared -> poc=1 on the next edge; poc falls at the 65th clk1 rise after the request.
REQ-038 poc_req pulsed in the cycle poc would deassert -> poc stays high and falls 64 complete periods later.
REQ-039 reset pulsed during PH1 -> clk1=0 and poc=1 on the next edge; after release the normal startup sequence follows.
